// File: rtl/prf_scoreboard.sv
// Physical register file busy scoreboard: tracks which physical registers await a producer,
// with immediate and latency-delayed wakeups, same-cycle wakeup bypass and branch checkpoints.
module prf_scoreboard #(
    parameter int PRF_SIZE    = 64,
    parameter int SET_PORTS   = 4,
    parameter int CLR_PORTS   = 4,
    parameter int SCHED_PORTS = 2,
    parameter int MAX_LAT     = 4,
    parameter int QRY_PORTS   = 16,
    parameter int CKPT_NUM    = 4,
    localparam int IDX_W      = $clog2(PRF_SIZE),
    localparam int LAT_W      = $clog2(MAX_LAT + 1),
    localparam int CK_W       = (CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1,
    localparam int CNT_W      = $clog2(PRF_SIZE + 1)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  clear,
    input  logic [SET_PORTS-1:0]                  set_valid,
    input  logic [SET_PORTS-1:0][IDX_W-1:0]       set_index,
    input  logic [CLR_PORTS-1:0]                  clr_valid,
    input  logic [CLR_PORTS-1:0][IDX_W-1:0]       clr_index,
    input  logic [SCHED_PORTS-1:0]                sched_valid,
    input  logic [SCHED_PORTS-1:0][IDX_W-1:0]     sched_index,
    input  logic [SCHED_PORTS-1:0][LAT_W-1:0]     sched_lat,
    input  logic                                  ckpt_save_valid,
    input  logic [CK_W-1:0]                       ckpt_save_id,
    input  logic                                  ckpt_restore_valid,
    input  logic [CK_W-1:0]                       ckpt_restore_id,
    input  logic [QRY_PORTS-1:0][IDX_W-1:0]       qry_index,
    output logic [QRY_PORTS-1:0]                  qry_busy,
    output logic [PRF_SIZE-1:0]                   busy_vec,
    output logic [CNT_W-1:0]                      busy_cnt
);

    // Requests are valid-only: there is no ready, every asserted valid is consumed in its cycle.
    logic [PRF_SIZE-1:0]                 sb_q, sb_d, sb_norm;
    logic [PRF_SIZE-1:0][LAT_W-1:0]      cnt_q, cnt_d;
    logic [CKPT_NUM-1:0][PRF_SIZE-1:0]   snap_q, snap_d;
    logic [CNT_W-1:0]                    busy_cnt_q, busy_cnt_d;
    logic [PRF_SIZE-1:0]                 set_now, clr_now;
    logic                                save_ok, restore_ok;

    function automatic logic [LAT_W-1:0] clamp_lat(input logic [LAT_W-1:0] l);
        if (l == '0)
            return LAT_W'(1);
        else if (l > LAT_W'(MAX_LAT))
            return LAT_W'(MAX_LAT);
        else
            return l;
    endfunction

    assign save_ok    = 32'(ckpt_save_id) < CKPT_NUM;
    assign restore_ok = 32'(ckpt_restore_id) < CKPT_NUM;

    // Index 0 is the hard-wired zero register and can never become busy.
    always_comb begin
        set_now = '0;
        clr_now = '0;
        for (int s = 0; s < SET_PORTS; s++)
            if (set_valid[s] && set_index[s] != '0)
                set_now[set_index[s]] = 1'b1;
        for (int c = 0; c < CLR_PORTS; c++)
            if (clr_valid[c])
                clr_now[clr_index[c]] = 1'b1;
        for (int p = 0; p < PRF_SIZE; p++)
            if (cnt_q[p] == LAT_W'(1))
                clr_now[p] = 1'b1;
    end

    always_comb begin
        qry_busy = '0;
        for (int q = 0; q < QRY_PORTS; q++)
            qry_busy[q] = sb_q[qry_index[q]] & ~clr_now[qry_index[q]] & (qry_index[q] != '0);
    end

    always_comb begin
        sb_norm = (sb_q | set_now) & ~clr_now;
        sb_d    = sb_norm;
        cnt_d   = '0;
        snap_d  = '0;
        for (int p = 0; p < PRF_SIZE; p++)
            cnt_d[p] = (cnt_q[p] != '0) ? cnt_q[p] - LAT_W'(1) : '0;
        // Ascending port order lets the highest-numbered sched port win on a shared index.
        for (int s = 0; s < SCHED_PORTS; s++)
            if (sched_valid[s] && sched_index[s] != '0)
                cnt_d[sched_index[s]] = clamp_lat(sched_lat[s]);
        for (int p = 0; p < PRF_SIZE; p++)
            if (set_now[p])
                cnt_d[p] = '0;
        for (int k = 0; k < CKPT_NUM; k++)
            snap_d[k] = snap_q[k] & ~clr_now;

        if (clear) begin
            sb_d   = '0;
            cnt_d  = '0;
            snap_d = '0;
        end else if (ckpt_restore_valid) begin
            sb_d = (restore_ok ? snap_q[ckpt_restore_id] : '0) & ~clr_now;
            for (int p = 0; p < PRF_SIZE; p++)
                if (!sb_d[p])
                    cnt_d[p] = '0;
        end else if (ckpt_save_valid && save_ok) begin
            snap_d[ckpt_save_id] = sb_norm;
        end

        busy_cnt_d = '0;
        for (int p = 0; p < PRF_SIZE; p++)
            busy_cnt_d = busy_cnt_d + CNT_W'(sb_d[p]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_q       <= '0;
            cnt_q      <= '0;
            snap_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            sb_q       <= sb_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_vec = sb_q;
    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_prf_scoreboard.sv
// Directed bench for prf_scoreboard: a vector table for single-port behaviour plus
// hand-written sequences for multi-port priority and reset during a pending wakeup.
module tb_prf_scoreboard;
    localparam int IW = 6;
    localparam int LW = 3;
    localparam int KW = 2;
    localparam int CW = 7;

    logic                clock = 1'b0;
    logic                reset, clear;
    logic [3:0]          set_valid;
    logic [3:0][IW-1:0]  set_index;
    logic [3:0]          clr_valid;
    logic [3:0][IW-1:0]  clr_index;
    logic [1:0]          sched_valid;
    logic [1:0][IW-1:0]  sched_index;
    logic [1:0][LW-1:0]  sched_lat;
    logic                ckpt_save_valid, ckpt_restore_valid;
    logic [KW-1:0]       ckpt_save_id, ckpt_restore_id;
    logic [15:0][IW-1:0] qry_index;
    logic [15:0]         qry_busy;
    logic [63:0]         busy_vec;
    logic [CW-1:0]       busy_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    prf_scoreboard dut (
        .clock(clock), .reset(reset), .clear(clear),
        .set_valid(set_valid), .set_index(set_index),
        .clr_valid(clr_valid), .clr_index(clr_index),
        .sched_valid(sched_valid), .sched_index(sched_index), .sched_lat(sched_lat),
        .ckpt_save_valid(ckpt_save_valid), .ckpt_save_id(ckpt_save_id),
        .ckpt_restore_valid(ckpt_restore_valid), .ckpt_restore_id(ckpt_restore_id),
        .qry_index(qry_index), .qry_busy(qry_busy),
        .busy_vec(busy_vec), .busy_cnt(busy_cnt)
    );

    always #5 clock = ~clock;

    // -1 in an index field means that request is not issued this cycle.
    typedef struct {
        int set_i; int clr_i; int sch_i; int sch_l; int sv_id; int rs_id; int clr_all;
        int q_i; int exp_q; int chk_i; int exp_bit; int exp_cnt;
    } vec_t;
    vec_t vecs[$];

    function automatic vec_t v(int set_i, int clr_i, int sch_i, int sch_l, int sv_id,
                               int rs_id, int clr_all, int q_i, int exp_q,
                               int chk_i, int exp_bit, int exp_cnt);
        vec_t r;
        r.set_i = set_i; r.clr_i = clr_i; r.sch_i = sch_i; r.sch_l = sch_l;
        r.sv_id = sv_id; r.rs_id = rs_id; r.clr_all = clr_all; r.q_i = q_i;
        r.exp_q = exp_q; r.chk_i = chk_i; r.exp_bit = exp_bit; r.exp_cnt = exp_cnt;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        reset = 1'b0; clear = 1'b0;
        set_valid = '0; set_index = '0; clr_valid = '0; clr_index = '0;
        sched_valid = '0; sched_index = '0; sched_lat = '0;
        ckpt_save_valid = 1'b0; ckpt_save_id = '0;
        ckpt_restore_valid = 1'b0; ckpt_restore_id = '0;
        qry_index = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_vec(input vec_t t, input int n);
        idle_inputs();
        if (t.set_i >= 0) begin set_valid[0] = 1'b1; set_index[0] = IW'(t.set_i); end
        if (t.clr_i >= 0) begin clr_valid[0] = 1'b1; clr_index[0] = IW'(t.clr_i); end
        if (t.sch_i >= 0) begin
            sched_valid[0] = 1'b1; sched_index[0] = IW'(t.sch_i); sched_lat[0] = LW'(t.sch_l);
        end
        if (t.sv_id >= 0) begin ckpt_save_valid = 1'b1; ckpt_save_id = KW'(t.sv_id); end
        if (t.rs_id >= 0) begin ckpt_restore_valid = 1'b1; ckpt_restore_id = KW'(t.rs_id); end
        clear = (t.clr_all != 0);
        qry_index[0] = IW'(t.q_i);
        @(negedge clock);
        check($sformatf("v%0d qry(%0d)", n, t.q_i), 64'(qry_busy[0]), 64'(t.exp_q));
        tick();
        check($sformatf("v%0d busy_vec[%0d]", n, t.chk_i), 64'(busy_vec[t.chk_i]), 64'(t.exp_bit));
        check($sformatf("v%0d busy_cnt", n), 64'(busy_cnt), 64'(t.exp_cnt));
    endtask

    initial begin
        // set_i clr_i sch_i lat sv rs clr  q_i eq  chk eb ec
        vecs.push_back(v( 5, -1, -1, 0, -1, -1, 0,  5, 0,  5, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0,  5, 1,  5, 1, 1));
        vecs.push_back(v(-1,  5, -1, 0, -1, -1, 0,  5, 0,  5, 0, 0));
        vecs.push_back(v( 7,  7, -1, 0, -1, -1, 0,  7, 0,  7, 0, 0));
        vecs.push_back(v( 9, -1, -1, 0, -1, -1, 0,  9, 0,  9, 1, 1));
        vecs.push_back(v(-1, -1,  9, 3, -1, -1, 0,  9, 1,  9, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0,  9, 1,  9, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0,  9, 1,  9, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0,  9, 0,  9, 0, 0));
        vecs.push_back(v( 3, -1, -1, 0, -1, -1, 0,  3, 0,  3, 1, 1));
        vecs.push_back(v( 4, -1, -1, 0, -1, -1, 0,  4, 0,  4, 1, 2));
        vecs.push_back(v(-1, -1, -1, 0,  0, -1, 0,  3, 1,  4, 1, 2));
        vecs.push_back(v(10, -1, -1, 0, -1, -1, 0, 10, 0, 10, 1, 3));
        vecs.push_back(v(-1,  3, 10, 4,  1, -1, 0,  3, 0,  3, 0, 2));
        vecs.push_back(v(-1, -1, -1, 0, -1,  0, 0, 10, 1, 10, 0, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1,  1, 0, 10, 0, 10, 1, 2));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0, 10, 1, 10, 1, 2));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0, 10, 1, 10, 1, 2));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0, 10, 1, 10, 1, 2));
        vecs.push_back(v(-1, 10, -1, 0, -1, -1, 0, 10, 0, 10, 0, 1));
        vecs.push_back(v(-1,  4, -1, 0, -1, -1, 0,  4, 0,  4, 0, 0));
        vecs.push_back(v( 0, -1, -1, 0, -1, -1, 0,  0, 0,  0, 0, 0));
        vecs.push_back(v(-1, -1,  0, 1, -1, -1, 0,  0, 0,  0, 0, 0));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0,  0, 0,  0, 0, 0));
        vecs.push_back(v(20, -1, -1, 0, -1, -1, 0, 20, 0, 20, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0,  2, -1, 0, 20, 1, 20, 1, 1));
        vecs.push_back(v(21, -1, -1, 0, -1, -1, 1, 20, 1, 21, 0, 0));
        vecs.push_back(v(-1, -1, -1, 0, -1,  2, 0, 20, 0, 20, 0, 0));
        vecs.push_back(v(30, -1, -1, 0, -1, -1, 0, 30, 0, 30, 1, 1));
        vecs.push_back(v(-1, -1, 30, 0, -1, -1, 0, 30, 1, 30, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0, 30, 0, 30, 0, 0));
        vecs.push_back(v(31, -1, -1, 0, -1, -1, 0, 31, 0, 31, 1, 1));
        vecs.push_back(v(-1, -1, 31, 7, -1, -1, 0, 31, 1, 31, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0, 31, 1, 31, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0, 31, 1, 31, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0, 31, 1, 31, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0, 31, 0, 31, 0, 0));
        vecs.push_back(v(40, -1, -1, 0, -1, -1, 0, 40, 0, 40, 1, 1));
        vecs.push_back(v(40, -1, 40, 1, -1, -1, 0, 40, 1, 40, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0, 40, 1, 40, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1, -1, 0, 40, 1, 40, 1, 1));
        vecs.push_back(v(-1, 40, -1, 0, -1, -1, 0, 40, 0, 40, 0, 0));
        vecs.push_back(v(50, -1, -1, 0, -1, -1, 0, 50, 0, 50, 1, 1));
        vecs.push_back(v(-1, -1, -1, 0,  3, -1, 0, 50, 1, 50, 1, 1));
        vecs.push_back(v(51, -1, -1, 0,  3,  3, 0, 51, 0, 51, 0, 1));
        vecs.push_back(v(-1, -1, -1, 0, -1,  3, 0, 50, 1, 51, 0, 1));
        vecs.push_back(v(-1, 50, -1, 0, -1, -1, 0, 50, 0, 50, 0, 0));

        // Reset and post-reset state.
        idle_inputs();
        reset = 1'b1;
        tick();
        tick();
        idle_inputs();
        for (int q = 0; q < 16; q++) qry_index[q] = IW'(q);
        check("reset busy_vec", busy_vec, 64'h0);
        check("reset busy_cnt", 64'(busy_cnt), 64'h0);
        @(negedge clock);
        check("reset qry_busy", 64'(qry_busy), 64'h0);
        tick();

        for (int i = 0; i < vecs.size(); i++)
            apply_vec(vecs[i], i);

        // Four set ports in one cycle, then partial clear with a bypassed query.
        idle_inputs();
        set_valid = 4'hF;
        for (int s = 0; s < 4; s++) set_index[s] = IW'(s + 1);
        tick();
        check("multi-set busy_vec", busy_vec, 64'h1E);
        check("multi-set busy_cnt", 64'(busy_cnt), 64'd4);
        idle_inputs();
        clr_valid = 4'b0011;
        clr_index[0] = IW'(1);
        clr_index[1] = IW'(2);
        for (int q = 0; q < 4; q++) qry_index[q] = IW'(q + 1);
        @(negedge clock);
        check("multi-clr qry_busy[3:0]", 64'(qry_busy[3:0]), 64'hC);
        tick();
        check("multi-clr busy_vec", busy_vec, 64'h18);
        check("multi-clr busy_cnt", 64'(busy_cnt), 64'd2);
        idle_inputs();
        clr_valid = 4'b1100;
        clr_index[2] = IW'(3);
        clr_index[3] = IW'(4);
        tick();
        check("multi-clr2 busy_cnt", 64'(busy_cnt), 64'd0);

        // Two sched ports hit index 60; port 1 (lat 3) must win over port 0 (lat 1).
        idle_inputs();
        set_valid[0] = 1'b1;
        set_index[0] = IW'(60);
        tick();
        idle_inputs();
        sched_valid = 2'b11;
        sched_index[0] = IW'(60); sched_lat[0] = LW'(1);
        sched_index[1] = IW'(60); sched_lat[1] = LW'(3);
        qry_index[0] = IW'(60);
        @(negedge clock);
        check("sched-prio T qry(60)", 64'(qry_busy[0]), 64'd1);
        tick();
        for (int i = 1; i <= 3; i++) begin
            idle_inputs();
            qry_index[0] = IW'(60);
            @(negedge clock);
            check($sformatf("sched-prio T+%0d qry(60)", i), 64'(qry_busy[0]), (i < 3) ? 64'd1 : 64'd0);
            tick();
        end
        check("sched-prio busy_vec[60]", 64'(busy_vec[60]), 64'd0);

        // Reset while a lat-4 wakeup on index 12 is pending.
        idle_inputs();
        set_valid[0] = 1'b1;
        set_index[0] = IW'(12);
        tick();
        idle_inputs();
        sched_valid[0] = 1'b1;
        sched_index[0] = IW'(12);
        sched_lat[0] = LW'(4);
        tick();
        for (int i = 1; i <= 2; i++) begin
            idle_inputs();
            tick();
            check($sformatf("pre-reset T+%0d busy_vec[12]", i), 64'(busy_vec[12]), 64'd1);
        end
        idle_inputs();
        reset = 1'b1;
        tick();
        idle_inputs();
        for (int q = 0; q < 16; q++) qry_index[q] = IW'(q);
        set_valid[0] = 1'b1;
        set_index[0] = IW'(12);
        check("mid-reset busy_vec", busy_vec, 64'h0);
        check("mid-reset busy_cnt", 64'(busy_cnt), 64'h0);
        @(negedge clock);
        check("mid-reset qry_busy", 64'(qry_busy), 64'h0);
        tick();
        check("re-set busy_vec", busy_vec, 64'h1000);
        check("re-set busy_cnt", 64'(busy_cnt), 64'd1);
        for (int i = 0; i < 5; i++) begin
            idle_inputs();
            qry_index[0] = IW'(12);
            @(negedge clock);
            check($sformatf("re-set hold%0d qry(12)", i), 64'(qry_busy[0]), 64'd1);
            tick();
            check($sformatf("re-set hold%0d busy_vec[12]", i), 64'(busy_vec[12]), 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
